// File: rtl/tron_plot_arbiter.sv
// tron_plot_arbiter
//   Sits between the two tron datapaths and vga_adapter. After reset it
//   sweeps the whole screen to BG_COLOUR while clearing a 1-bit occupancy
//   bitmap. On each tick in IDLE it latches both heads, reads their
//   occupancy, checks bounds and head-on, then plots A then B on the single
//   vga_adapter port. Any collision freezes the block in OVER until reset.
//
//   Handshake: tick is a one-cycle pulse accepted only in IDLE (busy=0);
//   a tick seen while busy=1 is dropped and latched into tick_missed.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   tick                   one-cycle pulse: heads have advanced
//   t1x/t1y, t2x/t2y       head positions of tron A / tron B
//   colour_a, colour_b     trail colours
//   x, y, colour, plot     vga_adapter write port (registered)
//   busy                   high in every state except IDLE
//   crash_a, crash_b       sticky collision flags
//   game_over              crash_a | crash_b
//   tick_missed            sticky: tick arrived while busy
//   state_dbg              current FSM state encoding
module tron_plot_arbiter #(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [7:0] t1x,
  input  logic [6:0] t1y,
  input  logic [7:0] t2x,
  input  logic [6:0] t2y,
  input  logic [2:0] colour_a,
  input  logic [2:0] colour_b,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       crash_a,
  output logic       crash_b,
  output logic       game_over,
  output logic       tick_missed,
  output logic [2:0] state_dbg
);

  localparam int         DEPTH  = SCREEN_W * SCREEN_H;
  localparam logic [7:0] W_LIM  = 8'(SCREEN_W);
  localparam logic [6:0] H_LIM  = 7'(SCREEN_H);
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_RD_A, S_RD_B, S_CHK, S_PLOT_A, S_PLOT_B, S_OVER
  } state_t;

  function automatic logic [14:0] addr_of(input logic [7:0] px, input logic [6:0] py);
    return 15'(py) * 15'(SCREEN_W) + 15'(px);
  endfunction

  // Unsigned compare also catches wrapped coordinates (0-1 = 255 / 127).
  function automatic logic in_bounds(input logic [7:0] px, input logic [6:0] py);
    return (px < W_LIM) && (py < H_LIM);
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic       clr_done_q, clr_done_d;
  logic [7:0] ax_q, ax_d, bx_q, bx_d;
  logic [6:0] ay_q, ay_d, by_q, by_d;
  logic [2:0] ca_q, ca_d, cb_q, cb_d;
  logic       occ_a_q, occ_a_d;
  logic       hit_a_q, hit_a_d, hit_b_q, hit_b_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       crash_a_q, crash_a_d, crash_b_q, crash_b_d;
  logic       tick_missed_q, tick_missed_d;

  // Occupancy bitmap: one write port, synchronous read with 1-cycle latency.
  logic        occ_mem [0:DEPTH-1];
  logic        rd_data_q;
  logic        mem_we, mem_wdata;
  logic [14:0] mem_waddr, mem_raddr;

  always_ff @(posedge clk) begin
    if (mem_we) occ_mem[mem_waddr] <= mem_wdata;
    rd_data_q <= occ_mem[mem_raddr];
  end

  logic same_pos, hit_a_now, hit_b_now;
  assign same_pos  = (ax_q == bx_q) && (ay_q == by_q);
  assign hit_a_now = occ_a_q   | ~in_bounds(ax_q, ay_q) | same_pos;
  assign hit_b_now = rd_data_q | ~in_bounds(bx_q, by_q) | same_pos;

  always_comb begin
    state_d       = state_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    clr_done_d    = clr_done_q;
    ax_d          = ax_q;
    ay_d          = ay_q;
    bx_d          = bx_q;
    by_d          = by_q;
    ca_d          = ca_q;
    cb_d          = cb_q;
    occ_a_d       = occ_a_q;
    hit_a_d       = hit_a_q;
    hit_b_d       = hit_b_q;
    x_d           = x_q;
    y_d           = y_q;
    colour_d      = colour_q;
    plot_d        = 1'b0;
    crash_a_d     = crash_a_q;
    crash_b_d     = crash_b_q;
    tick_missed_d = tick_missed_q | (tick && (state_q != S_IDLE));
    mem_we        = 1'b0;
    mem_wdata     = 1'b0;
    mem_waddr     = addr_of(cx_q, cy_q);
    mem_raddr     = '0;

    case (state_q)
      S_CLEAR: begin
        // Outputs are registered, so the final pixel is still on the port
        // during the clr_done cycle; IDLE begins the cycle after it.
        if (clr_done_q) begin
          state_d = S_IDLE;
        end else begin
          plot_d   = 1'b1;
          x_d      = cx_q;
          y_d      = cy_q;
          colour_d = BG_COLOUR;
          mem_we   = 1'b1;
          if (cx_q == X_LAST) begin
            cx_d = '0;
            if (cy_q == Y_LAST) clr_done_d = 1'b1;
            else                cy_d       = cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
      end
      S_IDLE: begin
        if (tick) begin
          ax_d    = t1x;
          ay_d    = t1y;
          bx_d    = t2x;
          by_d    = t2y;
          ca_d    = colour_a;
          cb_d    = colour_b;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        if (in_bounds(ax_q, ay_q)) mem_raddr = addr_of(ax_q, ay_q);
        state_d = S_RD_B;
      end
      S_RD_B: begin
        occ_a_d = rd_data_q;
        if (in_bounds(bx_q, by_q)) mem_raddr = addr_of(bx_q, by_q);
        state_d = S_CHK;
      end
      S_CHK: begin
        hit_a_d = hit_a_now;
        hit_b_d = hit_b_now;
        if (!hit_a_now) begin
          plot_d   = 1'b1;
          x_d      = ax_q;
          y_d      = ay_q;
          colour_d = ca_q;
        end
        state_d = S_PLOT_A;
      end
      S_PLOT_A: begin
        mem_we    = !hit_a_q;
        mem_wdata = 1'b1;
        mem_waddr = addr_of(ax_q, ay_q);
        if (!hit_b_q) begin
          plot_d   = 1'b1;
          x_d      = bx_q;
          y_d      = by_q;
          colour_d = cb_q;
        end
        state_d = S_PLOT_B;
      end
      S_PLOT_B: begin
        mem_we    = !hit_b_q;
        mem_wdata = 1'b1;
        mem_waddr = addr_of(bx_q, by_q);
        crash_a_d = crash_a_q | hit_a_q;
        crash_b_d = crash_b_q | hit_b_q;
        state_d   = (hit_a_q || hit_b_q) ? S_OVER : S_IDLE;
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_CLEAR;
      cx_q          <= '0;
      cy_q          <= '0;
      clr_done_q    <= 1'b0;
      ax_q          <= '0;
      ay_q          <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      ca_q          <= '0;
      cb_q          <= '0;
      occ_a_q       <= 1'b0;
      hit_a_q       <= 1'b0;
      hit_b_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= '0;
      plot_q        <= 1'b0;
      crash_a_q     <= 1'b0;
      crash_b_q     <= 1'b0;
      tick_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      clr_done_q    <= clr_done_d;
      ax_q          <= ax_d;
      ay_q          <= ay_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      ca_q          <= ca_d;
      cb_q          <= cb_d;
      occ_a_q       <= occ_a_d;
      hit_a_q       <= hit_a_d;
      hit_b_q       <= hit_b_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      crash_a_q     <= crash_a_d;
      crash_b_q     <= crash_b_d;
      tick_missed_q <= tick_missed_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign busy        = (state_q != S_IDLE);
  assign crash_a     = crash_a_q;
  assign crash_b     = crash_b_q;
  assign game_over   = crash_a_q | crash_b_q;
  assign tick_missed = tick_missed_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_tron_plot_arbiter.sv
// Directed bench for tron_plot_arbiter: clear sweep, plotting, collisions,
// bounds, head-on, dropped ticks and reset mid-sequence.
module tb_tron_plot_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, tick;
  logic [7:0] t1x, t2x;
  logic [6:0] t1y, t2y;
  logic [2:0] colour_a, colour_b;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, crash_a, crash_b, game_over, tick_missed;
  logic [2:0] state_dbg;

  tron_plot_arbiter dut (
    .clk(clk), .resetn(resetn), .tick(tick),
    .t1x(t1x), .t1y(t1y), .t2x(t2x), .t2y(t2y),
    .colour_a(colour_a), .colour_b(colour_b),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .crash_a(crash_a), .crash_b(crash_b), .game_over(game_over),
    .tick_missed(tick_missed), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: expected plotted pixels {x,y,colour} ----------------
  logic [17:0] exp_q[$];
  logic [17:0] exp_pix;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0d, expected no plot", x, y, colour);
      end else begin
        exp_pix = exp_q.pop_front();
        chk("plot_pixel", {14'd0, x, y, colour}, {14'd0, exp_pix});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    resetn = 1'b0;
    tick   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_xyc", {x, y, colour}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_flags", {crash_a, crash_b, game_over, tick_missed}, 0);
    resetn = 1'b1;
  endtask

  // Counts the sweep from its first plotted pixel; optionally pulses tick mid-sweep.
  task automatic clear_check(input bit tick_mid);
    int n = 0, pix_err = 0, waitc = 0;
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic [17:0] last_pix = '0;
    mon_en = 1'b0;
    @(negedge clk);
    while (plot !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("clear_start", plot, 1);
    chk("clear_first_px", {x, y, colour}, 0);
    while (plot === 1'b1 && n < 19300) begin
      ex = 8'(n % 160);
      ey = 7'(n / 160);
      if ({x, y, colour} !== {ex, ey, 3'b000}) pix_err++;
      last_pix = {x, y, colour};
      n++;
      tick = (tick_mid && n == 100);
      @(negedge clk);
    end
    tick = 1'b0;
    chk("clear_len", n, 19200);
    chk("clear_pixels_bad", pix_err, 0);
    chk("clear_last_px", last_pix, {8'd159, 7'd119, 3'd0});
    chk("clear_busy_after", busy, 0);
    mon_en = 1'b1;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy !== 1'b0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) chk("wait_idle_timeout", busy, 0);
  endtask

  task automatic drive_tick(input logic [7:0] ax, input logic [6:0] ay, input logic [2:0] ca,
                            input logic [7:0] bx, input logic [6:0] by, input logic [2:0] cb);
    t1x = ax; t1y = ay; colour_a = ca;
    t2x = bx; t2y = by; colour_b = cb;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    // Heads move on; the block must use the latched values.
    t1x = 8'($urandom_range(0, 255)); t1y = 7'($urandom_range(0, 127));
    t2x = 8'($urandom_range(0, 255)); t2y = 7'($urandom_range(0, 127));
    colour_a = 3'($urandom_range(0, 7)); colour_b = 3'($urandom_range(0, 7));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         pre_reset;
    logic [7:0] ax;
    logic [6:0] ay;
    logic [2:0] ca;
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] cb;
    bit         exp_pa, exp_pb, exp_ca, exp_cb, exp_missed;
    int         extra_at;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    if (v.pre_reset) begin
      reset_dut();
      clear_check(1'b0);
    end
    wait_idle();
    if (v.exp_pa) exp_q.push_back({v.ax, v.ay, v.ca});
    if (v.exp_pb) exp_q.push_back({v.bx, v.by, v.cb});
    drive_tick(v.ax, v.ay, v.ca, v.bx, v.by, v.cb);
    // now in cycle T+1
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 4) chk($sformatf("v%0d_plot_a", idx), plot, v.exp_pa);
      if (k == 5) chk($sformatf("v%0d_plot_b", idx), plot, v.exp_pb);
      if (k == 6) begin
        chk($sformatf("v%0d_busy", idx), busy, v.exp_ca | v.exp_cb);
        chk($sformatf("v%0d_crash_a", idx), crash_a, v.exp_ca);
        chk($sformatf("v%0d_crash_b", idx), crash_b, v.exp_cb);
        chk($sformatf("v%0d_game_over", idx), game_over, v.exp_ca | v.exp_cb);
        chk($sformatf("v%0d_tick_missed", idx), tick_missed, v.exp_missed);
      end
      tick = (k == v.extra_at);
    end
    tick = 1'b0;
  endtask

  task automatic over_test();
    int seen = 0;
    drive_tick(8'd40, 7'd40, 3'd1, 8'd41, 7'd41, 3'd2);
    repeat (10) begin
      @(negedge clk);
      if (plot === 1'b1) seen++;
    end
    chk("over_no_plot", seen, 0);
    chk("over_busy", busy, 1);
    chk("over_game_over", game_over, 1);
  endtask

  task automatic reset_mid_test();
    reset_dut();
    clear_check(1'b0);
    wait_idle();
    exp_q.push_back({8'd70, 7'd70, 3'd3});
    drive_tick(8'd70, 7'd70, 3'd3, 8'd71, 7'd71, 3'd5);
    repeat (3) @(negedge clk);
    chk("rm_plot_t4", plot, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rm_plot_async", plot, 0);
    chk("rm_x_async", x, 0);
    chk("rm_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_check(1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; tick = 1'b0;
    t1x = '0; t1y = '0; t2x = '0; t2y = '0; colour_a = '0; colour_b = '0;

    //           pre   ax      ay      ca     bx      by      cb     pa pb ca cb miss extra
    vecs[0] = '{1'b1, 8'd25,  7'd25,  3'd1, 8'd100, 7'd100, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 8'd159, 7'd119, 3'd7, 8'd0,   7'd0,   3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 8'd30,  7'd40,  3'd2, 8'd31,  7'd40,  3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2};
    vecs[3] = '{1'b0, 8'd26,  7'd25,  3'd1, 8'd25,  7'd25,  3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[4] = '{1'b1, 8'd50,  7'd60,  3'd5, 8'd50,  7'd60,  3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b0, 8'd255, 7'd5,   3'd1, 8'd10,  7'd127, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0};

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
      if (i == 3) over_test();
      if (i == 4) reset_mid_test();
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tron_plot_arbiter.md
Name: tron_plot_arbiter

Overview:
- Sits directly downstream of the two tron datapaths and directly upstream of vga_adapter.
- On each game tick it latches both tron head positions and checks each head against a 160x120 occupancy bitmap and the screen bounds.
- It then serialises the two head plots onto the single x/y/colour/plot port of vga_adapter.
- After reset it sweeps the whole screen to the background colour and clears the bitmap; on any collision it freezes and raises game_over.

Parameters:
- SCREEN_W, 160, playfield width in pixels; x valid range 0..SCREEN_W-1.
- SCREEN_H, 120, playfield height in pixels; y valid range 0..SCREEN_H-1.
- BG_COLOUR, 3'b000, colour written during the clear sweep.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle pulse: tron positions have advanced.
- t1x  in  8  tron A head x.
- t1y  in  7  tron A head y.
- t2x  in  8  tron B head x.
- t2y  in  7  tron B head y.
- colour_a  in  3  tron A colour.
- colour_b  in  3  tron B colour.
- x  out  8  vga_adapter x.
- y  out  7  vga_adapter y.
- colour  out  3  vga_adapter colour.
- plot  out  1  vga_adapter write enable.
- busy  out  1  high in every state except IDLE.
- crash_a  out  1  sticky: tron A collided.
- crash_b  out  1  sticky: tron B collided.
- game_over  out  1  sticky: crash_a | crash_b.
- tick_missed  out  1  sticky: a tick arrived while busy.

Behaviour:
- Clock and reset:
  - Single clock; resetn is asynchronous and active-low.
  - Reset forces state=CLEAR, sweep counters=0, x=0, y=0, colour=0, plot=0, and all sticky flags=0.
- Occupancy RAM:
  - SCREEN_W*SCREEN_H x 1 bit; address = y*SCREEN_W + x (15 bits).
  - Synchronous read, 1-cycle latency; single write port.
- CLEAR:
  - Row-major sweep, x fastest; one pixel per cycle, plot=1, colour=BG_COLOUR; writes occupancy 0.
  - Takes exactly SCREEN_W*SCREEN_H cycles (19200 at defaults).
  - After (159,119) the block enters IDLE with plot=0.
  - tick during CLEAR is ignored and sets tick_missed.
- IDLE:
  - plot=0.
  - On tick=1, latch t1x, t1y, t2x, t2y, colour_a, colour_b into internal registers; go to RD_A next cycle.
- Cycle-level sequence, with the tick sampled in cycle T:
  - T+1 RD_A: issue read at A's address.
  - T+2 RD_B: capture occ_a; issue read at B's address.
  - T+3 CHK: capture occ_b and evaluate:
    - hitA = occ_a | (xA>=SCREEN_W) | (yA>=SCREEN_H).
    - hitB = the same terms for B.
    - Head-on: if xA==xB and yA==yB, hitA=hitB=1.
    - The bounds test handles wrap: x 0-1=255 and y 0-1=127 both count as out of bounds.
    - Out-of-bounds addresses are never used to write RAM. The value read at an out-of-bounds address is don't-care.
  - T+4 PLOT_A: if !hitA, plot=1, x=xA, y=yA, colour=colour_a, and occupancy[A] set to 1. Otherwise plot=0.
  - T+5 PLOT_B: same for B with colour_b.
  - T+6: if hitA|hitB, set crash_a|=hitA and crash_b|=hitB, and go to OVER. Otherwise go to IDLE.
- Tick rules:
  - Tick-to-plot latency is 4 cycles for A and 5 for B.
  - A tick in any non-IDLE state is dropped and sets tick_missed.
- OVER:
  - plot=0; all further ticks are ignored.
  - Only resetn exits OVER, which restarts the CLEAR sweep.
- Other rules:
  - Reset asserted mid-sweep or mid-sequence aborts immediately.
  - No partial plot completes after reset is asserted.
  - busy=0 only in IDLE.

Test Plan:
- Reset, then run: plot=1 for exactly 19200 consecutive cycles, first pixel (0,0), last pixel (159,119), colour=000 throughout. busy falls on the following cycle.
- After clear, tick with A=(25,25) colour 001 and B=(100,100) colour 100: plot pulses at T+4 (25,25,001) and T+5 (100,100,100). No crash; IDLE at T+6.
- Second tick with A=(26,25) and B=(25,25): A plotted; B is not plotted. crash_b=1, crash_a=0, game_over=1. Subsequent ticks produce no plot.
- Head-on case, both at (50,60) on a fresh board: no plots; crash_a=crash_b=1.
- A at x=255 (decremented past 0) or y=127: crash_a=1; the RAM is not written.
- Tick at T+2 of a sequence sets tick_missed=1 and the sequence is unchanged. resetn low at T+4 gives plot=0 at once and CLEAR restarts from (0,0).
